pipe_phy_loopback_model: RTL and testbench

Synthesizable PIPE-side PHY model that sits directly downstream of the `PCIe` MAC's PIPE Tx interface and feeds its PIPE Rx interface, replacing the hand-driven `PhyStatus`/`RxStatus` stimulus in gen1 benches. It has three jobs:
- Loop Tx symbols back to Rx through a fixed-latency pipeline.
- Answer receiver-detect requests with the PIPE `PhyStatus`/`RxStatus` handshake.
- Acknowledge power-state changes.

---
 rtl/pipe_model_pkg.sv | 9 +
 rtl/pipe_delay_line.sv | 22 ++
 rtl/pipe_phy_loopback_model.sv | 105 ++++++++++
 tb/tb_pipe_phy_loopback_model.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_model_pkg.sv
// pipe_model_pkg: FSM states and PIPE encodings shared by the loopback PHY model
package pipe_model_pkg;
   typedef enum logic [1:0] {RST_WAIT, IDLE, DETECT, PD_CHANGE} pipeState_t;
   localparam logic [2:0] RXSTAT_DETECTED = 3'b011;
   localparam logic [1:0] PD_P0 = 2'b00;
   localparam logic [1:0] PD_P0S = 2'b01;
   localparam logic [1:0] PD_P1 = 2'b10;
   localparam logic [1:0] PD_P2 = 2'b11;
endpackage

// File: rtl/pipe_delay_line.sv
// pipe_delay_line: fixed-depth register chain that resets to a supplied value
module pipe_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] rstVal,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] stage [DEPTH];
   always_ff @(posedge CLK) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= rstVal;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end
   assign q = stage[DEPTH-1];
endmodule

// File: rtl/pipe_phy_loopback_model.sv
// pipe_phy_loopback_model: PIPE PHY stand-in that loops Tx to Rx and answers
// receiver-detect and power-state handshakes with PhyStatus/RxStatus
module pipe_phy_loopback_model import pipe_model_pkg::*; #(
   parameter int MAXPIPEWIDTH = 32,
   parameter int LANESNUMBER = 16,
   parameter int LOOP_LAT = 2,
   parameter int DETECT_LAT = 4,
   parameter int PD_LAT = 3,
   parameter int RESET_LAT = 8,
   parameter logic [LANESNUMBER-1:0] RX_PRESENT_MASK = '1
) (
   input  logic                                  CLK,
   input  logic                                  reset,
   input  logic [MAXPIPEWIDTH*LANESNUMBER-1:0]   TxData,
   input  logic [MAXPIPEWIDTH/8*LANESNUMBER-1:0] TxDataK,
   input  logic [LANESNUMBER-1:0]                TxDataValid,
   input  logic [LANESNUMBER-1:0]                TxElecIdle,
   input  logic [LANESNUMBER-1:0]                TxDetectRx_Loopback,
   input  logic [4*LANESNUMBER-1:0]              PowerDown,
   output logic [MAXPIPEWIDTH*LANESNUMBER-1:0]   RxData,
   output logic [MAXPIPEWIDTH/8*LANESNUMBER-1:0] RxDataK,
   output logic [LANESNUMBER-1:0]                RxDataValid,
   output logic [LANESNUMBER-1:0]                RxValid,
   output logic [LANESNUMBER-1:0]                RxElectricalIdle,
   output logic [3*LANESNUMBER-1:0]              RxStatus,
   output logic [LANESNUMBER-1:0]                PhyStatus
);
   localparam int DW = MAXPIPEWIDTH*LANESNUMBER;
   localparam int KW = MAXPIPEWIDTH/8*LANESNUMBER;
   localparam int BW = DW + KW + 3*LANESNUMBER;

   pipeState_t state;
   logic [3:0] cnt, pdQ, pd;
   logic detQ, det, phy;
   logic [3*LANESNUMBER-1:0] rxStat, detStat;
   logic unusedPd;

   // only lane 0 carries the power state; the other lanes' fields are ignored
   assign pd = PowerDown[3:0];
   assign unusedPd = ^PowerDown[4*LANESNUMBER-1:4];
   assign det = |TxDetectRx_Loopback;

   for (genvar l = 0; l < LANESNUMBER; l++) begin : g_stat
      assign detStat[3*l +: 3] = RX_PRESENT_MASK[l] ? RXSTAT_DETECTED : 3'b000;
   end

   pipe_delay_line #(.WIDTH(BW), .DEPTH(LOOP_LAT)) loopLine (
      .CLK(CLK),
      .reset(reset),
      .d({TxData, TxDataK, TxDataValid, TxElecIdle, TxDataValid & ~TxElecIdle}),
      .rstVal({{(DW+KW+LANESNUMBER){1'b0}}, {LANESNUMBER{1'b1}}, {LANESNUMBER{1'b0}}}),
      .q({RxData, RxDataK, RxDataValid, RxElectricalIdle, RxValid})
   );

   always_ff @(posedge CLK) begin
      if (reset) begin
         state <= RST_WAIT;
         cnt <= 4'(RESET_LAT-1);
         phy <= 1'b1;
         rxStat <= '0;
         detQ <= 1'b0;
         pdQ <= pd;
      end else begin
         detQ <= det;
         phy <= 1'b0;
         rxStat <= '0;
         case (state)
            RST_WAIT: begin
               pdQ <= pd;
               phy <= cnt != 4'd0;
               if (cnt == 4'd0) state <= IDLE;
               else cnt <= cnt - 4'd1;
            end
            IDLE: begin
               // pdQ already holds the new value while PD_CHANGE runs, so a
               // later change is seen as a fresh difference on return here
               pdQ <= pd;
               if (pd != pdQ) begin
                  state <= PD_CHANGE;
                  cnt <= 4'(PD_LAT-1);
               end else if (det && !detQ && pd[1:0] == PD_P1) begin
                  state <= DETECT;
                  cnt <= 4'(DETECT_LAT-1);
               end
            end
            DETECT: begin
               if (cnt == 4'd0) begin
                  state <= IDLE;
                  phy <= 1'b1;
                  rxStat <= detStat;
               end else cnt <= cnt - 4'd1;
            end
            default: begin
               if (cnt == 4'd0) begin
                  state <= IDLE;
                  phy <= 1'b1;
               end else cnt <= cnt - 4'd1;
            end
         endcase
      end
   end

   assign PhyStatus = {LANESNUMBER{phy}};
   assign RxStatus = rxStat;
endmodule

// File: tb/tb_pipe_phy_loopback_model.sv
// tb_pipe_phy_loopback_model: scoreboard bench for the PIPE loopback PHY model
module tb_pipe_phy_loopback_model;
   localparam int L = 16;
   localparam int DW = 512;
   localparam int KW = 64;

   typedef struct {
      int cyc;
      logic [3*L-1:0] st;
      logic [3*L-1:0] stM;
   } pulse_t;
   typedef struct {
      int cyc;
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic [L-1:0] v;
      logic [L-1:0] rv;
      logic [L-1:0] ei;
   } rx_t;

   logic CLK = 1'b0;
   logic reset = 1'b1;
   logic [DW-1:0] TxData = '0;
   logic [KW-1:0] TxDataK = '0;
   logic [L-1:0] TxDataValid = '0;
   logic [L-1:0] TxElecIdle = '1;
   logic [L-1:0] TxDetectRx_Loopback = '0;
   logic [4*L-1:0] PowerDown = {16{4'h2}};
   logic [DW-1:0] RxData;
   logic [KW-1:0] RxDataK;
   logic [L-1:0] RxDataValid, RxValid, RxElectricalIdle, PhyStatus;
   logic [3*L-1:0] RxStatus, RxStatusM;
   logic [DW-1:0] unusedRxDataM;
   logic [KW-1:0] unusedRxDataKM;
   logic [L-1:0] unusedRxDataValidM, unusedRxValidM, unusedRxElectricalIdleM, unusedPhyStatusM;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit watch = 0;
   pulse_t pq[$];
   rx_t lq[$];
   logic [3*L-1:0] full = {16{3'b011}};
   logic [3*L-1:0] part = {{8{3'b000}}, {8{3'b011}}};

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc++;

   pipe_phy_loopback_model dut (
      .CLK(CLK), .reset(reset), .TxData(TxData), .TxDataK(TxDataK),
      .TxDataValid(TxDataValid), .TxElecIdle(TxElecIdle),
      .TxDetectRx_Loopback(TxDetectRx_Loopback), .PowerDown(PowerDown),
      .RxData(RxData), .RxDataK(RxDataK), .RxDataValid(RxDataValid),
      .RxValid(RxValid), .RxElectricalIdle(RxElectricalIdle),
      .RxStatus(RxStatus), .PhyStatus(PhyStatus)
   );

   pipe_phy_loopback_model #(.RX_PRESENT_MASK(16'h00FF)) dutM (
      .CLK(CLK), .reset(reset), .TxData(TxData), .TxDataK(TxDataK),
      .TxDataValid(TxDataValid), .TxElecIdle(TxElecIdle),
      .TxDetectRx_Loopback(TxDetectRx_Loopback), .PowerDown(PowerDown),
      .RxData(unusedRxDataM), .RxDataK(unusedRxDataKM), .RxDataValid(unusedRxDataValidM),
      .RxValid(unusedRxValidM), .RxElectricalIdle(unusedRxElectricalIdleM),
      .RxStatus(RxStatusM), .PhyStatus(unusedPhyStatusM)
   );

   task automatic fail(input string n, input logic [DW-1:0] a, input logic [DW-1:0] e);
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, a, e);
   endtask

   task automatic chk(input string n, input logic [DW-1:0] a, input logic [DW-1:0] e);
      total++;
      if (a !== e) fail(n, a, e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic drive(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic [L-1:0] v, input logic [L-1:0] ei);
      TxData = d;
      TxDataK = k;
      TxDataValid = v;
      TxElecIdle = ei;
   endtask

   task automatic expPulse(input int at, input logic [3*L-1:0] st, input logic [3*L-1:0] stM);
      pulse_t p;
      p.cyc = at;
      p.st = st;
      p.stM = stM;
      pq.push_back(p);
   endtask

   task automatic expRx(input int at, input logic [DW-1:0] d, input logic [KW-1:0] k, input logic [L-1:0] v, input logic [L-1:0] ei);
      rx_t r;
      r.cyc = at;
      r.d = d;
      r.k = k;
      r.v = v;
      r.ei = ei;
      r.rv = v & ~ei;
      lq.push_back(r);
   endtask

   always @(negedge CLK) begin
      if (watch) begin
         if (PhyStatus != '0) begin
            if (pq.size() == 0) fail("unexpected_pulse", PhyStatus, 0);
            else begin
               pulse_t p;
               p = pq.pop_front();
               chk("pulse_cycle", cyc, p.cyc);
               chk("pulse_phystatus", PhyStatus, 16'hFFFF);
               chk("pulse_rxstatus", RxStatus, p.st);
               chk("pulse_rxstatus_mask", RxStatusM, p.stM);
            end
         end else begin
            chk("idle_rxstatus", RxStatus, 0);
            if (pq.size() != 0 && pq[0].cyc < cyc) begin
               pulse_t p;
               p = pq.pop_front();
               fail("missed_pulse", cyc, p.cyc);
            end
         end
      end
      if (RxDataValid != '0) begin
         if (lq.size() == 0) fail("unexpected_rx", RxDataValid, 0);
         else begin
            rx_t r;
            r = lq.pop_front();
            chk("rx_cycle", cyc, r.cyc);
            chk("rx_data", RxData, r.d);
            chk("rx_datak", RxDataK, r.k);
            chk("rx_datavalid", RxDataValid, r.v);
            chk("rx_valid", RxValid, r.rv);
            chk("rx_elecidle", RxElectricalIdle, r.ei);
         end
      end else if (lq.size() != 0 && lq[0].cyc < cyc) begin
         rx_t r;
         r = lq.pop_front();
         fail("missed_rx", cyc, r.cyc);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] d;
      tick(3);
      chk("reset_phystatus", PhyStatus, 16'hFFFF);
      chk("reset_rxstatus", RxStatus, 0);
      chk("reset_rxdata", RxData, 0);
      chk("reset_rxdatak", RxDataK, 0);
      chk("reset_rxdatavalid", RxDataValid, 0);
      chk("reset_rxvalid", RxValid, 0);
      chk("reset_rxelecidle", RxElectricalIdle, 16'hFFFF);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("rstwait_phystatus_high", PhyStatus, 16'hFFFF);
         tick(1);
      end
      chk("rstwait_phystatus_fall", PhyStatus, 0);
      chk("rstwait_elecidle", RxElectricalIdle, 16'hFFFF);
      watch = 1;
      tick(2);
      // detect in P1; held request must not retrigger
      TxDetectRx_Loopback = '1;
      expPulse(cyc + 5, full, part);
      tick(12);
      TxDetectRx_Loopback = '0;
      tick(2);
      // second edge arriving during DETECT is lost
      TxDetectRx_Loopback = '1;
      expPulse(cyc + 5, full, part);
      tick(2);
      TxDetectRx_Loopback = '0;
      tick(1);
      TxDetectRx_Loopback = '1;
      tick(8);
      TxDetectRx_Loopback = '0;
      tick(2);
      // P1->P0 with a simultaneous detect edge: only the power pulse
      PowerDown = '0;
      TxDetectRx_Loopback = '1;
      expPulse(cyc + 4, '0, '0);
      tick(6);
      TxDetectRx_Loopback = '0;
      tick(2);
      // detect outside P1 is ignored
      TxDetectRx_Loopback = '1;
      tick(8);
      TxDetectRx_Loopback = '0;
      tick(2);
      // P0->P2, then P2->P1 during PD_CHANGE gives a second pulse
      PowerDown = {16{4'h3}};
      expPulse(cyc + 4, '0, '0);
      tick(2);
      PowerDown = {16{4'h2}};
      expPulse(cyc + 6, '0, '0);
      tick(10);
      // back-to-back loopback vectors
      d = {{15{32'h1234_5678}}, 32'h0000_00BC};
      drive(d, 64'h1, 16'hFFFF, 16'h0);
      expRx(cyc + 2, d, 64'h1, 16'hFFFF, 16'h0);
      tick(1);
      d = {16{32'h5A5A_A5A5}};
      drive(d, 64'hF0F0_F0F0_0F0F_0F0F, 16'h00FF, 16'h0F0F);
      expRx(cyc + 2, d, 64'hF0F0_F0F0_0F0F_0F0F, 16'h00FF, 16'h0F0F);
      tick(1);
      for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
      drive(d, 64'h8000_0000_0000_0001, 16'h8001, 16'h0001);
      expRx(cyc + 2, d, 64'h8000_0000_0000_0001, 16'h8001, 16'h0001);
      tick(1);
      drive('0, '0, '0, '1);
      tick(4);
      chk("drain_elecidle", RxElectricalIdle, 16'hFFFF);
      chk("drain_datavalid", RxDataValid, 0);
      tick(2);
      // reset during DETECT with data in flight
      TxDetectRx_Loopback = '1;
      tick(1);
      d = {16{32'hCAFE_F00D}};
      drive(d, '1, '1, '0);
      tick(1);
      watch = 0;
      reset = 1'b1;
      drive('0, '0, '0, '1);
      tick(1);
      chk("midrst_phystatus", PhyStatus, 16'hFFFF);
      chk("midrst_rxstatus", RxStatus, 0);
      chk("midrst_rxdata", RxData, 0);
      chk("midrst_rxvalid", RxValid, 0);
      chk("midrst_elecidle", RxElectricalIdle, 16'hFFFF);
      TxDetectRx_Loopback = '0;
      tick(2);
      chk("midrst_rxstatus_late", RxStatus, 0);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("rerst_phystatus_high", PhyStatus, 16'hFFFF);
         tick(1);
      end
      chk("rerst_phystatus_fall", PhyStatus, 0);
      watch = 1;
      tick(10);
      chk("pulse_queue_empty", pq.size(), 0);
      chk("rx_queue_empty", lq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
